iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Multi-cycle 16-bit shift unit for the datapath's shift instructions, built from a single bidirectional one-bit stage iterated under a small FSM. Adds left shifts (the opposite direction to the existing right-shift barrel stages) and keeps logical right shift. It sits beside the ALU. The control unit launches it with a start/done handshake and stalls on `busy`.

## Interface
- `WIDTH`, default 16: data width.
- `SHW`, default 4: shift-amount width; `$clog2(WIDTH)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `dir`  in  1  0 = shift left (zero fill at bit 0), 1 = shift right.
- `arith`  in  1  with `dir`=1, sign-fill right shift; see Configuration.
- `data_in`  in  WIDTH  operand.
- `shamt`  in  SHW  shift amount, 0..15.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; result valid on `data_out` this cycle.
- `data_out`  out  WIDTH  working/result register.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**:
  - On `start`=1, load `data_out`←`data_in`, `cnt`←`shamt`, and latch `dir`/`arith`.
  - Next state is SHIFT if `shamt`≠0, otherwise DONE.
- **SHIFT**: each cycle, `data_out` ← one-bit shift of `data_out` and `cnt` ← `cnt`−1.
  - Left shift: `out[i]=in[i-1]`, `out[0]=0`.
  - Right shift: `out[i]=in[i+1]`, `out[15]` = fill bit.
  - When `cnt`==1 (last shift), next state is DONE.
- **DONE**: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `data_out` holds the result after DONE until the next accepted `start`.
- Operand and control fields are latched at start, so `data_in`, `shamt`, `dir` and `arith` may change freely while busy.
- `start` in SHIFT or DONE is ignored. It is not queued.
- Intermediate `data_out` values during SHIFT are visible but not meaningful; consumers qualify the result with `done`.
- `shamt` never exceeds 15, so the result is never fully cleared by count alone. A value of 15 leaves at most one original bit (plus sign fill).

## Timing
- Reset (async assert, sync release): state=IDLE, `busy`=0, `done`=0, `data_out`=0, `cnt`=0.
- Reset asserted mid-SHIFT or in DONE aborts immediately. No `done` pulse is produced.
- Latency: `start` accepted at edge T, `done` high during cycle T+`shamt`+1.
  - `shamt`=0 gives `done` at T+1.
  - `shamt`=15 gives `done` at T+16.
- `busy` rises the cycle after acceptance and falls the cycle after `done`.
- Minimum spacing between accepted starts is `shamt`+2 cycles.

## Configuration
- `ITERATIVE_SHIFTER_ARITH_EN`:
  - **Defined:** with `dir`=1 and `arith`=1, the right-shift fill bit is the latched MSB (arithmetic shift). With `dir`=0, `arith` is ignored.
  - **Undefined:** the `arith` port still exists but is ignored. The fill bit is always 0.

## Structure
- Package `shifter_pkg` holds:
  - the FSM state enum typedef (IDLE/SHIFT/DONE);
  - the `WIDTH`/`SHW` defaults;
  - the direction encodings `DIR_LEFT`=0 and `DIR_RIGHT`=1.
- Sub-module `shift1_bidir`: combinational one-bit shifter with inputs `in`, `dir`, `fill` and output `out`, built as one 2:1 mux per bit. Instantiated once; its output feeds the `data_out` register.

## Test plan
- Reset: assert `rst_n`=0 at cycle 3 of `shamt`=8 → `busy`=0, `done`=0, `data_out`=16'h0000 immediately. No later `done` pulse.
- Left: `data_in`=16'h0001, `shamt`=4, `dir`=0 → `done` at T+5, `data_out`=16'h0010.
- Right logical: 16'h8000, `shamt`=15, `dir`=1, `arith`=0 → `done` at T+16, `data_out`=16'h0001.
- Zero shift: 16'hABCD, `shamt`=0 → `done` at T+1, `data_out`=16'hABCD, `busy` high for exactly one cycle.
- Arithmetic: 16'h8000, `shamt`=3, `dir`=1, `arith`=1 → 16'hF000 with the macro defined, 16'h1000 without it.
- Ignored start: during SHIFT of 16'h00F0 left by 4, pulse `start` with 16'hFFFF → single `done`, `data_out`=16'h0F00.

Source files
------------

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the iterative shift unit: default data and
// shift-amount widths, the direction encodings and the FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package shifter_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift1_bidir.sv
// -----------------------------------------------------------------------------
// shift1_bidir
// Combinational single-position shifter, one 2:1 mux per bit.
// Ports:
//   in   [WIDTH] operand
//   dir  [1]     0 = left (zero into bit 0), 1 = right (fill into MSB)
//   fill [1]     bit shifted into the MSB on a right shift
//   out  [WIDTH] shifted result
// -----------------------------------------------------------------------------
module shift1_bidir
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] left_val;
  logic [WIDTH-1:0] right_val;

  assign left_val  = {in[WIDTH-2:0], 1'b0};
  assign right_val = {fill, in[WIDTH-1:1]};
  assign out       = (dir == DIR_RIGHT) ? right_val : left_val;

endmodule

// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
// Multi-cycle shift unit: one bidirectional one-bit stage iterated shamt
// times under an IDLE/SHIFT/DONE FSM with a start/done handshake.
// Optional feature macro: ITERATIVE_SHIFTER_ARITH_EN -- when defined, a right
// shift with arith=1 fills with the MSB; otherwise arith is ignored.
// Ports:
//   clk      [1]     rising-edge clock
//   rst_n    [1]     asynchronous active-low reset
//   start    [1]     launch request, honoured only in IDLE
//   dir      [1]     0 = left, 1 = right
//   arith    [1]     sign-fill request for right shifts
//   data_in  [WIDTH] operand
//   shamt    [SHW]   shift amount
//   busy     [1]     high while not IDLE
//   done     [1]     one-cycle result-valid pulse
//   data_out [WIDTH] working/result register
// -----------------------------------------------------------------------------
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             dir_q;
  logic             fill;
  logic [WIDTH-1:0] shifted;

`ifdef ITERATIVE_SHIFTER_ARITH_EN
  logic arith_q;

  // The working register's MSB is the original sign for the whole operation,
  // since every right step copies it back in.
  assign fill = arith_q & data_out[WIDTH-1];
`else
  logic unused_arith;

  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  shift1_bidir #(.WIDTH(WIDTH)) u_stage (
    .in   (data_out),
    .dir  (dir_q),
    .fill (fill),
    .out  (shifted)
  );

  // busy and done are registered alongside the state so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_q    <= DIR_LEFT;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ITERATIVE_SHIFTER_ARITH_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_out <= data_in;
            cnt      <= shamt;
            dir_q    <= dir;
`ifdef ITERATIVE_SHIFTER_ARITH_EN
            arith_q  <= arith;
`endif
            busy     <= 1'b1;
            if (shamt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_out <= shifted;
          cnt      <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// tb_iterative_shifter
// Self-checking bench for iterative_shifter: directed cases followed by
// random operations, compared against an arithmetic shift model.
// Honours ITERATIVE_SHIFTER_ARITH_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic        arith;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] data_out;

  int compared;
  int mismatched;

  iterative_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir      (dir),
    .arith    (arith),
    .data_in  (data_in),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the shift expressed directly with shift operators.
  function automatic logic [15:0] refShift(input logic [15:0] d, input int s,
                                           input logic dr, input logic ar);
    logic signed [15:0] sd;
    sd = d;
    if (dr == 1'b0) return d << s;
`ifdef ITERATIVE_SHIFTER_ARITH_EN
    if (ar) return sd >>> s;
`endif
    return d >> s;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an operation for one cycle, then scrambles the inputs to show
  // they are not needed after acceptance.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] s,
                               input logic dr, input logic ar);
    data_in = d;
    shamt   = s;
    dir     = dr;
    arith   = ar;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = 16'($urandom);
    shamt   = 4'($urandom);
    dir     = 1'($urandom);
    arith   = 1'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic countDones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [15:0] d,
                       input logic [3:0] s, input logic dr, input logic ar);
    int lat;
    logic [15:0] exp;
    exp = refShift(d, int'(s), dr, ar);
    applyStimulus(d, s, dr, ar);
    checkOutput({tag, "_busy_rise"}, 16'(busy), 16'd1);
    waitDone(lat);
    checkOutput({tag, "_latency"}, 16'(lat), 16'(s));
    checkOutput({tag, "_data"}, data_out, exp);
    @(posedge clk); #1;
    checkOutput({tag, "_busy_fall"}, {14'd0, busy, done}, 16'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    int n;
    int lat;
    compared   = 0;
    mismatched = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    dir     = 1'b0;
    arith   = 1'b0;
    data_in = '0;
    shamt   = '0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_state", {13'd0, busy, done, 1'b0}, 16'd0);
    checkOutput("reset_data", data_out, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    runOp("left4", 16'h0001, 4'd4, 1'b0, 1'b0);
    runOp("right15", 16'h8000, 4'd15, 1'b1, 1'b0);
    runOp("zero", 16'hABCD, 4'd0, 1'b0, 1'b0);
    runOp("arith3", 16'h8000, 4'd3, 1'b1, 1'b1);
    runOp("arith_left", 16'hC001, 4'd2, 1'b0, 1'b1);

    // A start during SHIFT must not be taken or queued.
    applyStimulus(16'h00F0, 4'd4, 1'b0, 1'b0);
    @(posedge clk); #1;
    start   = 1'b1;
    data_in = 16'hFFFF;
    shamt   = 4'd0;
    @(posedge clk); #1;
    start   = 1'b0;
    waitDone(lat);
    checkOutput("ignored_start_data", data_out, 16'h0F00);
    countDones(20, n);
    checkOutput("ignored_start_no_extra_done", 16'(n), 16'd0);
    checkOutput("ignored_start_idle", 16'(busy), 16'd0);

    // Reset in the middle of an 8-step shift aborts with no done pulse.
    applyStimulus(16'h1234, 4'd8, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_flags", {14'd0, busy, done}, 16'd0);
    checkOutput("abort_data", data_out, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    countDones(20, n);
    checkOutput("abort_no_done", 16'(n), 16'd0);
    checkOutput("abort_data_after", data_out, 16'h0000);

    $display("[TB] random cases");
    for (int i = 0; i < 30; i++) begin
      runOp($sformatf("rand%0d", i), 16'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
